mode_counter: RTL
=================

# mode_counter

Programmable-limit up/down counter: the parametrised successor to the fixed-`MAX` free-running counter used across the design.

- Adds a runtime limit, a direction control, a synchronous load and three end-of-range modes: wrap, saturate and one-shot.
- Reports wrap and completion events as single-cycle pulses or sticky flags.
- Intended for baud/tick generators, timeouts and address sequencers where the terminal count or direction changes at runtime.

## Interface
Parameters:
- `WIDTH`, default 8: counter width in bits.
- `PRESCALE`, default 4: enabled pulses per count step. Only used when the prescaler is compiled in; must be ≥1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `enabled`  in  1  count request, sampled each cycle.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `mode`  in  2  0 = wrap, 1 = saturate, 2 = one-shot, 3 = treated as wrap.
- `limit`  in  WIDTH  terminal value; counting range is 0..`limit`.
- `load`  in  1  synchronous load request.
- `load_value`  in  WIDTH  value to load.
- `value`  out  WIDTH  current count, registered.
- `rollover`  out  1  one-cycle pulse on an up-wrap or up-completion.
- `underflow`  out  1  one-cycle pulse on a down-wrap or down-completion.
- `done`  out  1  sticky one-shot completion flag, registered.
- `at_limit`  out  1  combinational: `up ? (value >= limit) : (value == 0)`.

## Operation
- **Priority** per rising edge: `reset` > `load` > count step.
- **Reset:** `value`=0, `rollover`=0, `underflow`=0, `done`=0, prescaler=0.
- **Load:** `value` ← min(`load_value`, `limit`). Load also clears `done` and the prescaler, and suppresses any step in the same cycle.
- **Step condition:** a step occurs when `enabled`=1, no load, and `done`=0. With the prescaler compiled in, the prescaler must also be at terminal (see Configuration).
- **Up step, `value` < `limit`:** `value`+1.
- **Up step, `value` ≥ `limit`:**
  - wrap: `value`←0, `rollover`=1.
  - saturate: `value`←`limit`, no pulse.
  - one-shot: `value`←`limit`, `rollover`=1, `done`←1.
- **Down step, `value` > 0:** `value`−1, also when `value` > `limit` after a runtime limit change.
- **Down step, `value` == 0:**
  - wrap: `value`←`limit`, `underflow`=1.
  - saturate: hold 0.
  - one-shot: hold 0, `underflow`=1, `done`←1.
- **`done`=1:** `enabled` is ignored and `value` is frozen until `load` or `reset`. Changing `mode` does not clear `done`.
- **Pulse outputs:** `rollover` and `underflow` are 0 in every cycle without a qualifying event. They are never both 1.
- **Arithmetic:** unsigned modulo 2^WIDTH. The comparison `value` ≥ `limit` makes a lowered `limit` take effect on the next up step.
- **`limit`=0:**
  - wrap: `value` stays 0 and a `rollover` (up) or `underflow` (down) pulse occurs on every step.
  - one-shot: completes on the first step.
- **`limit`=2^WIDTH−1:** behaves as a full-range counter.

## Timing
- **Step latency:** `value` changes one cycle after the sampled `enabled`.
- **Pulses:** `rollover`/`underflow` are registered on the same edge as the wrapped `value`, so the pulse and the new value (0 or `limit`) are visible in the same cycle.
- **`done`:** rises on the same edge as the completing pulse.
- **`at_limit`:** has zero latency from `value`, `limit` and `up`.
- **Control inputs** (`mode`, `up`, `limit`) are sampled each edge. A change takes effect on the next step, with no internal pipeline.
- **Reset mid-count** overrides everything in that cycle; outputs read reset values on the next cycle.

## Configuration
- **Macro `MODE_COUNTER_PRESCALE_EN`.**
- **Defined:**
  - An internal prescaler of width $clog2(`PRESCALE`) (min 1) counts `enabled` pulses while `done`=0.
  - A step occurs only on the `enabled` pulse that brings the prescaler to `PRESCALE`−1; the prescaler then returns to 0.
  - `PRESCALE`=1 is equivalent to undefined.
  - The prescaler is cleared by `reset` and `load`.
- **Undefined:** every qualifying `enabled` cycle is a step; `PRESCALE` is ignored and no prescaler logic is generated.

## Test plan
- **Up-wrap:** WIDTH=8, `limit`=5, `mode`=0, `up`=1, `enabled` held for 7 cycles from reset → `value` 1,2,3,4,5,0,1; `rollover`=1 only in the cycle `value`=0.
- **Down-wrap:** `load`=1 with `load_value`=200, `limit`=10 → `value`=10. Then `up`=0, 11 enabled cycles → `value` reaches 0 and then 10, with `underflow`=1 in the cycle `value`=10.
- **Saturate up:** `limit`=3, `mode`=1, 6 enabled cycles → `value` holds at 3; `rollover` and `underflow` stay 0; `at_limit`=1.
- **One-shot:** `limit`=2, `mode`=2, `up`=1, enabled held → `value` 1,2,2; `rollover` pulses once; `done`=1 and stays 1. Then `load` with `load_value`=0 → `done`=0 and counting resumes.
- **Simultaneous events and runtime limit change:**
  - `load` and `enabled` in the same cycle → the loaded value is taken and no step occurs.
  - `reset` during a one-shot count → all outputs 0 on the next cycle.
  - `limit` lowered from 9 to 4 while `value`=7, wrap mode, up → next step gives `value`=0 with a `rollover` pulse.
- **Prescaler (`MODE_COUNTER_PRESCALE_EN` defined):** `PRESCALE`=4, enabled held → `value` increments every 4th cycle. A `load` mid-period restarts the 4-cycle period.

Source files
------------

// File: rtl/mode_counter.sv
`default_nettype none
// ============================================================================
// Module      : mode_counter
// Description : Programmable-limit up/down counter with synchronous load and
//               wrap / saturate / one-shot end-of-range modes. Wrap and
//               completion events appear as single-cycle rollover/underflow
//               pulses; one-shot completion sets a sticky done flag.
//               Optional prescaler compiled in with MODE_COUNTER_PRESCALE_EN:
//               a step then happens on every PRESCALE-th enabled pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mode_counter #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enabled,
   input  logic             up,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] limit,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value,
   output logic             rollover,
   output logic             underflow,
   output logic             done,
   output logic             at_limit
);

   // Mode encodings; 2'd3 falls through to wrap behaviour.
   localparam logic [1:0] MODE_SATURATE = 2'd1;
   localparam logic [1:0] MODE_ONESHOT  = 2'd2;

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   // A prescale factor below one has no meaning; stop elaboration.
   generate
      if (PRESCALE < 1) begin : g_bad_prescale
         $error("mode_counter: PRESCALE must be >= 1");
      end
   endgenerate

   logic [WIDTH-1:0] value_q, value_d;
   logic             rollover_q, rollover_d;
   logic             underflow_q, underflow_d;
   logic             done_q, done_d;

   // Count request before any prescaling: load wins, done freezes the count.
   logic count_req;
   logic step;

   assign count_req = enabled & ~load & ~done_q;

`ifdef MODE_COUNTER_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic          presc_term;

   assign presc_term = (presc_q == PRESC_LAST);
   assign step       = count_req & presc_term;

   // Prescaler next value: cleared by load, advanced by each counted enable.
   always_comb begin
      presc_d = presc_q;
      if (load) begin
         presc_d = '0;
      end else if (count_req) begin
         presc_d = presc_term ? '0 : presc_q + PW'(1);
      end
   end

   // Prescaler register.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end
`else
   assign step = count_req;
`endif

   // Next count value, event pulses and sticky completion flag.
   always_comb begin
      value_d     = value_q;
      rollover_d  = 1'b0;
      underflow_d = 1'b0;
      done_d      = done_q;

      if (load) begin
         // Loaded values are clamped into the 0..limit range.
         value_d = (load_value > limit) ? limit : load_value;
         done_d  = 1'b0;
      end else if (step) begin
         if (up) begin
            // >= so that a limit lowered below value acts on the next step.
            if (value_q < limit) begin
               value_d = value_q + ONE;
            end else if (mode == MODE_SATURATE) begin
               value_d = limit;
            end else if (mode == MODE_ONESHOT) begin
               value_d    = limit;
               rollover_d = 1'b1;
               done_d     = 1'b1;
            end else begin
               value_d    = ZERO;
               rollover_d = 1'b1;
            end
         end else begin
            if (value_q != ZERO) begin
               value_d = value_q - ONE;
            end else if (mode == MODE_SATURATE) begin
               value_d = ZERO;
            end else if (mode == MODE_ONESHOT) begin
               value_d     = ZERO;
               underflow_d = 1'b1;
               done_d      = 1'b1;
            end else begin
               value_d     = limit;
               underflow_d = 1'b1;
            end
         end
      end
   end

   // Counter state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         value_q     <= '0;
         rollover_q  <= 1'b0;
         underflow_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         value_q     <= value_d;
         rollover_q  <= rollover_d;
         underflow_q <= underflow_d;
         done_q      <= done_d;
      end
   end

   assign value     = value_q;
   assign rollover  = rollover_q;
   assign underflow = underflow_q;
   assign done      = done_q;
   assign at_limit  = up ? (value_q >= limit) : (value_q == ZERO);

endmodule
`default_nettype wire
